router_ext_port_buffer: RTL and testbench



---
 rtl/router_ext_port_buffer.sv | 167 ++++++++++++++++
 tb/tb_router_ext_port_buffer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_ext_port_buffer.sv
// router_ext_port_buffer
//   Bidirectional buffer between one external device and one router port.
//   Two independent show-ahead FIFOs: ingress (device -> router) and
//   egress (router -> device), both using the pending/pop handshake.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   dev_data_in/dev_pndng_in      ingress word offered by the device
//   dev_pop                       ingress word accepted this cycle
//   rtr_data_out/rtr_pndng        ingress head presented to the router
//   rtr_popin                     router consumes ingress head
//   rtr_data_in/rtr_pndng_in      egress word offered by the router
//   rtr_pop                       egress word accepted this cycle
//   dev_data_out/dev_pndng        egress head presented to the device
//   dev_popin                     device consumes egress head
//   flush                         synchronous clear of both FIFOs
//   ing_count/egr_count           occupancy
//   ing_afull/egr_afull           occupancy >= AF_THRESH
//   pop_err                       sticky pop-while-empty: [0] ingress, [1] egress

// One show-ahead FIFO direction.
//   pndng_in/data_in -> push (accept) ; data_out/pndng <- popin
module router_ext_port_fifo #(
    parameter int unsigned DATA_W    = 40,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = 12,
    parameter int unsigned CW        = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pndng_in,
    output logic              push,
    output logic [DATA_W-1:0] data_out,
    output logic              pndng,
    input  logic              popin,
    output logic [CW-1:0]     count,
    output logic              afull,
    output logic              err
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              pop;

    // A full FIFO refuses pushes even when a pop happens in the same cycle.
    assign push     = pndng_in & (count < CW'(DEPTH)) & ~flush & ~rst;
    assign pop      = popin & (count != '0) & ~flush;
    assign pndng    = (count != '0);
    // When empty, mem[rd_ptr] may be the slot currently being written; mask it.
    assign data_out = pndng ? mem[rd_ptr] : '0;
    assign afull    = (count >= CW'(AF_THRESH));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            // Popping an empty FIFO is ignored but remembered; a pop during
            // flush is not an error.
            if (popin && count == '0 && !flush) begin
                err <= 1'b1;
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

module router_ext_port_buffer #(
    parameter int unsigned DATA_W    = 40,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = 12,
    parameter int unsigned CW        = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] dev_data_in,
    input  logic              dev_pndng_in,
    output logic              dev_pop,
    output logic [DATA_W-1:0] rtr_data_out,
    output logic              rtr_pndng,
    input  logic              rtr_popin,
    input  logic [DATA_W-1:0] rtr_data_in,
    input  logic              rtr_pndng_in,
    output logic              rtr_pop,
    output logic [DATA_W-1:0] dev_data_out,
    output logic              dev_pndng,
    input  logic              dev_popin,
    input  logic              flush,
    output logic [CW-1:0]     ing_count,
    output logic [CW-1:0]     egr_count,
    output logic              ing_afull,
    output logic              egr_afull,
    output logic [1:0]        pop_err
);
    logic ing_err;
    logic egr_err;

    router_ext_port_fifo #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH),
        .CW        (CW)
    ) u_ing (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .data_in  (dev_data_in),
        .pndng_in (dev_pndng_in),
        .push     (dev_pop),
        .data_out (rtr_data_out),
        .pndng    (rtr_pndng),
        .popin    (rtr_popin),
        .count    (ing_count),
        .afull    (ing_afull),
        .err      (ing_err)
    );

    router_ext_port_fifo #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH),
        .CW        (CW)
    ) u_egr (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .data_in  (rtr_data_in),
        .pndng_in (rtr_pndng_in),
        .push     (rtr_pop),
        .data_out (dev_data_out),
        .pndng    (dev_pndng),
        .popin    (dev_popin),
        .count    (egr_count),
        .afull    (egr_afull),
        .err      (egr_err)
    );

    assign pop_err = {egr_err, ing_err};
endmodule

// File: tb/tb_router_ext_port_buffer.sv
// Self-checking bench for router_ext_port_buffer (DATA_W=40, DEPTH=16, AF_THRESH=12).
module tb_router_ext_port_buffer;
    localparam int unsigned DW = 40;
    localparam int unsigned CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] dev_data_in;
    logic          dev_pndng_in;
    logic          dev_pop;
    logic [DW-1:0] rtr_data_out;
    logic          rtr_pndng;
    logic          rtr_popin;
    logic [DW-1:0] rtr_data_in;
    logic          rtr_pndng_in;
    logic          rtr_pop;
    logic [DW-1:0] dev_data_out;
    logic          dev_pndng;
    logic          dev_popin;
    logic          flush;
    logic [CW-1:0] ing_count;
    logic [CW-1:0] egr_count;
    logic          ing_afull;
    logic          egr_afull;
    logic [1:0]    pop_err;

    int unsigned total  = 0;
    int unsigned passed = 0;

    router_ext_port_buffer #(
        .DATA_W    (DW),
        .DEPTH     (16),
        .AF_THRESH (12)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .dev_data_in  (dev_data_in),
        .dev_pndng_in (dev_pndng_in),
        .dev_pop      (dev_pop),
        .rtr_data_out (rtr_data_out),
        .rtr_pndng    (rtr_pndng),
        .rtr_popin    (rtr_popin),
        .rtr_data_in  (rtr_data_in),
        .rtr_pndng_in (rtr_pndng_in),
        .rtr_pop      (rtr_pop),
        .dev_data_out (dev_data_out),
        .dev_pndng    (dev_pndng),
        .dev_popin    (dev_popin),
        .flush        (flush),
        .ing_count    (ing_count),
        .egr_count    (egr_count),
        .ing_afull    (ing_afull),
        .egr_afull    (egr_afull),
        .pop_err      (pop_err)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are then driven and outputs sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dev_data_in  = '0;
        dev_pndng_in = 1'b0;
        rtr_popin    = 1'b0;
        rtr_data_in  = '0;
        rtr_pndng_in = 1'b0;
        dev_popin    = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst          = 1'b1;
        dev_pndng_in = 1'b1;
        dev_data_in  = 40'h77;
        #1;
        total++;
        if (dev_pop !== 1'b0) $display("FAIL reset_dev_pop: got %b want 0", dev_pop);
        else passed++;
        tick();
        total++;
        if (dev_pop !== 1'b0) $display("FAIL reset_dev_pop2: got %b want 0", dev_pop);
        else passed++;
        tick();
        rst = 1'b0;
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if ({rtr_pndng, dev_pndng, rtr_data_out, dev_data_out, ing_count, egr_count,
                 ing_afull, egr_afull, pop_err, dev_pop, rtr_pop} !== '0)
                $display("FAIL reset_idle: cycle %0d outputs not all zero (ing_count=%0d egr_count=%0d pop_err=%b rtr_pndng=%b dev_pndng=%b)",
                         i, ing_count, egr_count, pop_err, rtr_pndng, dev_pndng);
            else passed++;
            tick();
        end
    endtask

    task automatic test_ingress_stream();
        int unsigned sent = 0;
        int unsigned rcvd = 0;
        int unsigned cyc  = 0;
        while (rcvd < 5 && cyc < 30) begin
            dev_pndng_in = (sent < 5);
            dev_data_in  = 40'(sent + 1);
            rtr_popin    = rtr_pndng;
            #1;
            if (cyc == 0) begin
                total++;
                if (rtr_pndng !== 1'b0) $display("FAIL stream_no_fallthrough: rtr_pndng=%b want 0", rtr_pndng);
                else passed++;
            end
            if (cyc == 1) begin
                total++;
                if (rtr_pndng !== 1'b1 || rtr_data_out !== 40'h1)
                    $display("FAIL stream_first_latency: pndng=%b data=%h want 1 / 0000000001", rtr_pndng, rtr_data_out);
                else passed++;
            end
            if (sent < 5) begin
                total++;
                if (dev_pop !== 1'b1) $display("FAIL stream_dev_pop: word %0d got %b want 1", sent + 1, dev_pop);
                else passed++;
                sent++;
            end
            if (rtr_popin) begin
                total++;
                if (rtr_data_out !== 40'(rcvd + 1))
                    $display("FAIL stream_data: idx %0d got %h want %h", rcvd, rtr_data_out, 40'(rcvd + 1));
                else passed++;
                rcvd++;
            end
            total++;
            if (ing_count > 2) $display("FAIL stream_count: got %0d want <=2", ing_count);
            else passed++;
            tick();
            cyc++;
        end
        idle_inputs();
        total++;
        if (rcvd != 5 || ing_count !== 5'd0)
            $display("FAIL stream_done: received %0d count %0d want 5 / 0", rcvd, ing_count);
        else passed++;
    endtask

    task automatic test_fill_full();
        for (int i = 0; i < 16; i++) begin
            dev_pndng_in = 1'b1;
            dev_data_in  = 40'(32'h100 + i);
            #1;
            total++;
            if (dev_pop !== 1'b1 || ing_count !== 5'(i) || ing_afull !== (i >= 12))
                $display("FAIL fill_step: i=%0d pop=%b count=%0d afull=%b want 1/%0d/%b",
                         i, dev_pop, ing_count, ing_afull, i, (i >= 12));
            else passed++;
            tick();
        end
        dev_data_in = 40'h200;
        rtr_popin   = 1'b1;
        #1;
        total++;
        if (ing_count !== 5'd16 || ing_afull !== 1'b1 || dev_pop !== 1'b0)
            $display("FAIL fill_full: count=%0d afull=%b pop=%b want 16/1/0", ing_count, ing_afull, dev_pop);
        else passed++;
        total++;
        if (rtr_data_out !== 40'h100) $display("FAIL fill_head: got %h want 0000000100", rtr_data_out);
        else passed++;
        tick();
        rtr_popin = 1'b0;
        #1;
        total++;
        if (ing_count !== 5'd15 || dev_pop !== 1'b1)
            $display("FAIL fill_resume: count=%0d pop=%b want 15/1", ing_count, dev_pop);
        else passed++;
        tick();
        dev_pndng_in = 1'b0;
        for (int i = 0; i < 16; i++) begin
            logic [DW-1:0] exp;
            exp = (i < 15) ? 40'(32'h101 + i) : 40'h200;
            rtr_popin = 1'b1;
            #1;
            total++;
            if (rtr_data_out !== exp || rtr_pndng !== 1'b1)
                $display("FAIL drain_data: idx %0d got %h pndng %b want %h / 1", i, rtr_data_out, rtr_pndng, exp);
            else passed++;
            tick();
        end
        idle_inputs();
        #1;
        total++;
        if (ing_count !== 5'd0 || rtr_pndng !== 1'b0 || rtr_data_out !== '0 || pop_err !== 2'b00)
            $display("FAIL drain_empty: count=%0d pndng=%b data=%h err=%b want 0/0/0/00",
                     ing_count, rtr_pndng, rtr_data_out, pop_err);
        else passed++;
    endtask

    task automatic test_bidir();
        logic [DW-1:0] ing_src [20];
        logic [DW-1:0] egr_src [20];
        int unsigned ii = 0, ir = 0, ei = 0, er = 0, cyc = 0;
        for (int i = 0; i < 20; i++) begin
            ing_src[i] = 40'({$urandom(), $urandom()});
            egr_src[i] = 40'({$urandom(), $urandom()});
        end
        while ((ir < 20 || er < 20) && cyc < 1000) begin
            dev_pndng_in = (ii < 20) && ($urandom_range(0, 3) != 0);
            dev_data_in  = (ii < 20) ? ing_src[ii] : '0;
            rtr_pndng_in = (ei < 20) && ($urandom_range(0, 3) != 0);
            rtr_data_in  = (ei < 20) ? egr_src[ei] : '0;
            rtr_popin    = rtr_pndng && ($urandom_range(0, 1) == 0);
            dev_popin    = dev_pndng && ($urandom_range(0, 3) == 0);
            #1;
            if (rtr_popin) begin
                total++;
                if (rtr_data_out !== ing_src[ir])
                    $display("FAIL bidir_ing: idx %0d got %h want %h", ir, rtr_data_out, ing_src[ir]);
                else passed++;
                ir++;
            end
            if (dev_popin) begin
                total++;
                if (dev_data_out !== egr_src[er])
                    $display("FAIL bidir_egr: idx %0d got %h want %h", er, dev_data_out, egr_src[er]);
                else passed++;
                er++;
            end
            if (dev_pop) ii++;
            if (rtr_pop) ei++;
            tick();
            cyc++;
        end
        idle_inputs();
        total++;
        if (ir != 20 || er != 20)
            $display("FAIL bidir_timeout: ingress rcvd %0d egress rcvd %0d want 20/20", ir, er);
        else passed++;
    endtask

    task automatic test_err_flush();
        rtr_popin = 1'b1;
        tick();
        rtr_popin = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            total++;
            if (pop_err !== 2'b01) $display("FAIL err_sticky: cycle %0d got %b want 01", i, pop_err);
            else passed++;
            tick();
        end
        for (int i = 0; i < 7; i++) begin
            dev_pndng_in = 1'b1;
            dev_data_in  = 40'(32'h300 + i);
            tick();
        end
        dev_pndng_in = 1'b0;
        #1;
        total++;
        if (ing_count !== 5'd7) $display("FAIL flush_pre_count: got %0d want 7", ing_count);
        else passed++;
        flush        = 1'b1;
        dev_pndng_in = 1'b1;
        rtr_pndng_in = 1'b1;
        rtr_popin    = 1'b1;
        dev_popin    = 1'b1;
        #1;
        total++;
        if (dev_pop !== 1'b0 || rtr_pop !== 1'b0)
            $display("FAIL flush_block: dev_pop=%b rtr_pop=%b want 0/0", dev_pop, rtr_pop);
        else passed++;
        tick();
        idle_inputs();
        #1;
        total++;
        if (ing_count !== 5'd0 || egr_count !== 5'd0 || rtr_pndng !== 1'b0 || rtr_data_out !== '0)
            $display("FAIL flush_empty: ing=%0d egr=%0d pndng=%b data=%h want 0/0/0/0",
                     ing_count, egr_count, rtr_pndng, rtr_data_out);
        else passed++;
        total++;
        if (pop_err !== 2'b01) $display("FAIL flush_err_kept: got %b want 01", pop_err);
        else passed++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 9; i++) begin
            rtr_pndng_in = 1'b1;
            rtr_data_in  = 40'(32'h400 + i);
            tick();
        end
        rtr_pndng_in = 1'b0;
        #1;
        total++;
        if (egr_count !== 5'd9 || dev_pndng !== 1'b1 || dev_data_out !== 40'h400)
            $display("FAIL midrst_pre: count=%0d pndng=%b head=%h want 9/1/0000000400",
                     egr_count, dev_pndng, dev_data_out);
        else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (dev_pndng !== 1'b0 || egr_count !== 5'd0 || pop_err !== 2'b00 || dev_data_out !== '0)
            $display("FAIL midrst_post: pndng=%b count=%0d err=%b data=%h want 0/0/00/0",
                     dev_pndng, egr_count, pop_err, dev_data_out);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            rtr_pndng_in = 1'b1;
            rtr_data_in  = 40'(32'hA1 + i);
            tick();
        end
        rtr_pndng_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dev_popin = 1'b1;
            #1;
            total++;
            if (dev_data_out !== 40'(32'hA1 + i))
                $display("FAIL midrst_flow: idx %0d got %h want %h", i, dev_data_out, 40'(32'hA1 + i));
            else passed++;
            tick();
        end
        idle_inputs();
        #1;
        total++;
        if (egr_count !== 5'd0 || pop_err !== 2'b00)
            $display("FAIL midrst_end: count=%0d err=%b want 0/00", egr_count, pop_err);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_ingress_stream();
        test_fill_full();
        test_bidir();
        test_err_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
